// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel: FSM state encoding and period helpers.
package pwm_pkg;

  typedef enum logic {
    PWM_IDLE = 1'b0,
    PWM_RUN  = 1'b1
  } pwm_state_e;

  // Last value the period counter reaches before wrapping.
  function automatic int pwm_maxc(input int bit_width);
    return (1 << bit_width) - 2;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick divider for the PWM channel: one Tick every PreActive+1 clocks.
// PreActive is shadowed and only changes when Load is asserted.
module pwm_prescaler #(
  parameter int PrescaleWidth = 4
) (
  input  logic                     CLK,
  input  logic                     _RST,
  input  logic                     Clear,
  input  logic                     Load,
  input  logic [PrescaleWidth-1:0] PrescaleIn,
  output logic                     Tick
);

  logic [PrescaleWidth-1:0] precnt_q, precnt_d;
  logic [PrescaleWidth-1:0] preact_q, preact_d;

  assign Tick = (precnt_q == preact_q);

  always_comb begin
    preact_d = Load ? PrescaleIn : preact_q;
    if (Clear || Tick) begin
      precnt_d = '0;
    end else begin
      precnt_d = precnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      precnt_q <= '0;
      preact_q <= '0;
    end else begin
      precnt_q <= precnt_d;
      preact_q <= preact_d;
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// Single shadowed PWM channel: fixed period of 2^BitWidth-1 prescaled ticks.
// Optional output polarity inversion is enabled by defining PWM_POLARITY_EN.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int BitWidth      = 8,
  parameter int PrescaleWidth = 4
) (
  input  logic                     CLK,
  input  logic                     _RST,
  input  logic                     Enable,
  input  logic [BitWidth-1:0]      DutyIn,
  input  logic [PrescaleWidth-1:0] PrescaleIn,
`ifdef PWM_POLARITY_EN
  input  logic                     Polarity,
`endif
  output logic                     PwmOut,
  output logic                     PeriodStart,
  output logic [BitWidth-1:0]      DutyActive
);

  localparam logic [BitWidth-1:0] MAXC = BitWidth'(pwm_maxc(BitWidth));

  pwm_state_e          state_q;
  logic [BitWidth-1:0] count_q, count_d;
  logic [BitWidth-1:0] duty_q;
  logic                pol_q;
  logic                pwm_q;
  logic                pstart_q;

  logic tick;
  logic run_go;
  logic boundary;
  logic pol_in;

`ifdef PWM_POLARITY_EN
  assign pol_in = Polarity;
`else
  assign pol_in = 1'b0;
`endif

  assign run_go   = (state_q == PWM_RUN) && Enable;
  assign boundary = run_go && tick && (count_q == MAXC);

  // Prescaler is held cleared whenever the channel is not actively counting.
  pwm_prescaler #(
    .PrescaleWidth(PrescaleWidth)
  ) u_prescaler (
    .CLK       (CLK),
    ._RST      (_RST),
    .Clear     (!run_go),
    .Load      ((state_q == PWM_IDLE) || boundary),
    .PrescaleIn(PrescaleIn),
    .Tick      (tick)
  );

  always_comb begin
    count_d = count_q;
    if (!run_go || boundary) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q  <= PWM_IDLE;
      count_q  <= '0;
      duty_q   <= '0;
      pol_q    <= 1'b0;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      count_q <= count_d;
      case (state_q)
        PWM_IDLE: begin
          duty_q   <= DutyIn;
          pol_q    <= pol_in;
          pwm_q    <= pol_in;
          pstart_q <= Enable;
          if (Enable) begin
            state_q <= PWM_RUN;
          end
        end
        PWM_RUN: begin
          if (!Enable) begin
            state_q  <= PWM_IDLE;
            pwm_q    <= pol_q;
            pstart_q <= 1'b0;
          end else begin
            // Compare uses the count of the clock just ending, so the output lags by one.
            pwm_q    <= (count_q < duty_q) ^ pol_q;
            pstart_q <= boundary;
            if (boundary) begin
              duty_q <= DutyIn;
              pol_q  <= pol_in;
            end
          end
        end
        default: begin
          state_q <= PWM_IDLE;
        end
      endcase
    end
  end

  assign PwmOut      = pwm_q;
  assign PeriodStart = pstart_q;
  assign DutyActive  = duty_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Self-checking bench for pwm_channel: period-arithmetic model plus directed waveform checks.
module tb_pwm_channel;

  localparam int BW   = 8;
  localparam int PW   = 4;
  localparam int NCNT = (1 << BW) - 1;

  logic          CLK        = 1'b0;
  logic          RST_n      = 1'b0;
  logic          Enable     = 1'b1;
  logic [BW-1:0] DutyIn     = 8'h80;
  logic [PW-1:0] PrescaleIn = '0;
`ifdef PWM_POLARITY_EN
  logic          Polarity   = 1'b0;
  wire           pol_in     = Polarity;
`else
  wire           pol_in     = 1'b0;
`endif

  logic          PwmOut;
  logic          PeriodStart;
  logic [BW-1:0] DutyActive;

  int total = 0;
  int bad   = 0;

  pwm_channel #(
    .BitWidth     (BW),
    .PrescaleWidth(PW)
  ) dut (
    .CLK        (CLK),
    ._RST       (RST_n),
    .Enable     (Enable),
    .DutyIn     (DutyIn),
    .PrescaleIn (PrescaleIn),
`ifdef PWM_POLARITY_EN
    .Polarity   (Polarity),
`endif
    .PwmOut     (PwmOut),
    .PeriodStart(PeriodStart),
    .DutyActive (DutyActive)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks clocks elapsed since the current period began (k) and the
  // shadowed duty/prescale; output after edge k reflects tick (k-1)/(P+1).
  bit m_run = 0;
  int m_k   = 0;
  int m_D   = 0;
  int m_P   = 0;
  bit m_pol = 0;
  bit m_pwm = 0;
  bit m_ps  = 0;

  initial forever begin
    @(posedge CLK or negedge RST_n);
    if (!RST_n) begin
      m_run = 0; m_k = 0; m_D = 0; m_P = 0; m_pol = 0; m_pwm = 0; m_ps = 0;
    end else if (!m_run) begin
      m_D   = int'(DutyIn);
      m_P   = int'(PrescaleIn);
      m_pol = pol_in;
      m_pwm = pol_in;
      m_ps  = Enable;
      m_k   = 0;
      m_run = Enable;
    end else if (!Enable) begin
      m_run = 0;
      m_pwm = m_pol;
      m_ps  = 0;
    end else begin
      m_k++;
      m_pwm = (((m_k - 1) / (m_P + 1)) < m_D) ^ m_pol;
      m_ps  = 0;
      if (m_k == NCNT * (m_P + 1)) begin
        m_k   = 0;
        m_ps  = 1;
        m_D   = int'(DutyIn);
        m_P   = int'(PrescaleIn);
        m_pol = pol_in;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("model_pwm", {31'd0, PwmOut}, {31'd0, m_pwm});
    chk("model_ps", {31'd0, PeriodStart}, {31'd0, m_ps});
    chk("model_duty", {24'd0, DutyActive}, m_D);
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic enter(input int d, input int p);
    Enable = 1'b0;
    step();
    step();
    DutyIn     = d[BW-1:0];
    PrescaleIn = p[PW-1:0];
    Enable     = 1'b1;
    step();
  endtask

  task automatic run(input int n, output int highs, output int first_hi,
                     output int first_ps, output int nps);
    highs = 0; first_hi = -1; first_ps = -1; nps = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (PwmOut) begin
        highs++;
        if (first_hi < 0) first_hi = i;
      end
      if (PeriodStart) begin
        nps++;
        if (first_ps < 0) first_ps = i;
      end
    end
  endtask

  initial begin
    int h, fh, fp, np;

    // Asynchronous reset with Enable high and a pending duty.
    #3;
    chk("rst_pwm", {31'd0, PwmOut}, 0);
    chk("rst_duty", {24'd0, DutyActive}, 0);
    chk("rst_ps", {31'd0, PeriodStart}, 0);
    step();
    Enable = 1'b0;
    RST_n  = 1'b1;
    step();
    chk("idle_duty", {24'd0, DutyActive}, 32'h80);
    chk("idle_pwm", {31'd0, PwmOut}, 0);

    // Basic waveform, duty 3, no prescale.
    PrescaleIn = '0;
    DutyIn     = 8'd3;
    Enable     = 1'b1;
    step();
    chk("entry_ps", {31'd0, PeriodStart}, 1);
    chk("entry_pwm", {31'd0, PwmOut}, 0);
    run(255, h, fh, fp, np);
    chk("basic_high", h, 3);
    chk("basic_first_high", fh, 1);
    chk("basic_next_ps", fp, 255);
    chk("basic_ps_count", np, 1);

    // Extremes.
    enter(0, 0);
    run(3 * 255, h, fh, fp, np);
    chk("duty0_high", h, 0);
    chk("duty0_ps_count", np, 3);
    enter(255, 0);
    step();
    chk("dutyff_first", {31'd0, PwmOut}, 1);
    run(3 * 255, h, fh, fp, np);
    chk("dutyff_high", h, 3 * 255);
    chk("dutyff_ps_count", np, 3);

    // Shadowing: duty change mid-period waits for the boundary.
    enter(10, 0);
    h = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (PwmOut) h++;
      if (i == 50) DutyIn = 8'd200;
      if (i == 254) chk("shadow_duty_before", {24'd0, DutyActive}, 10);
    end
    chk("shadow_high_old", h, 10);
    chk("shadow_duty_after", {24'd0, DutyActive}, 200);
    chk("shadow_boundary_ps", {31'd0, PeriodStart}, 1);
    run(255, h, fh, fp, np);
    chk("shadow_high_new", h, 200);

    // Prescale 3, then a mid-period prescale change.
    enter(2, 3);
    h = 0; fp = -1;
    for (int i = 1; i <= 1020; i++) begin
      step();
      if (PwmOut) h++;
      if (PeriodStart && fp < 0) fp = i;
      if (i == 100) PrescaleIn = '0;
    end
    chk("pre_high", h, 8);
    chk("pre_period", fp, 1020);
    run(255, h, fh, fp, np);
    chk("pre_new_high", h, 2);
    chk("pre_new_period", fp, 255);

    // Abort at count 1, then re-enter.
    enter(100, 0);
    step();
    chk("abort_running", {31'd0, PwmOut}, 1);
    Enable = 1'b0;
    DutyIn = 8'd55;
    step();
    chk("abort_pwm", {31'd0, PwmOut}, 0);
    chk("abort_ps", {31'd0, PeriodStart}, 0);
    step();
    chk("abort_idle_duty", {24'd0, DutyActive}, 55);
    Enable = 1'b1;
    step();
    chk("reentry_ps", {31'd0, PeriodStart}, 1);
    chk("reentry_pwm", {31'd0, PwmOut}, 0);
    run(255, h, fh, fp, np);
    chk("reentry_high", h, 55);
    chk("reentry_period", fp, 255);

    // Reset mid-period takes effect without a clock edge.
    run(20, h, fh, fp, np);
    chk("midrst_before", {31'd0, PwmOut}, 1);
    RST_n = 1'b0;
    #1;
    chk("midrst_pwm", {31'd0, PwmOut}, 0);
    chk("midrst_duty", {24'd0, DutyActive}, 0);
    chk("midrst_ps", {31'd0, PeriodStart}, 0);
    step();
    RST_n = 1'b1;
    step();
    chk("postrst_entry_ps", {31'd0, PeriodStart}, 1);
    chk("postrst_duty", {24'd0, DutyActive}, 55);
    run(10, h, fh, fp, np);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
